latch_bank_reg: RTL and testbench

- Parametrised successor to the single-bit resettable storage cell.
- Holds CHANNELS words of WIDTH bits each, with complementary outputs q and qn per bit.
- Writes go into a shadow array. A commit pulse transfers all pending shadow words to the outputs in the same cycle, so a group of channels updates atomically.
- Sits between the control/debug write path and downstream datapath configuration inputs.

---
 rtl/latch_bank_reg_if.sv | 25 ++
 rtl/latch_bank_reg.sv | 62 ++++++
 tb/tb_latch_bank_reg.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/latch_bank_reg_if.sv
// latch_bank_reg_if: write/commit bus and committed-value outputs of the latch bank.
interface latch_bank_reg_if #(
    parameter int WIDTH = 8,
    parameter int CHANNELS = 4,
    localparam int SEL_W = $clog2(CHANNELS)
);
    logic                      wr_en;
    logic [SEL_W-1:0]          ch_sel;
    logic [1:0]                op;
    logic [WIDTH-1:0]          data;
    logic                      ser_in;
    logic                      commit;
    logic [CHANNELS*WIDTH-1:0] q;
    logic [CHANNELS*WIDTH-1:0] qn;
    logic [CHANNELS-1:0]       pending;
    logic                      sel_err;
    modport master (
        output wr_en, ch_sel, op, data, ser_in, commit,
        input  q, qn, pending, sel_err
    );
    modport slave (
        input  wr_en, ch_sel, op, data, ser_in, commit,
        output q, qn, pending, sel_err
    );
endinterface

// File: rtl/latch_bank_reg.sv
// latch_bank_reg: shadowed multi-channel register bank with atomic commit to q/qn.
// Writes land in a shadow array; commit copies every pending shadow word to q.
module latch_bank_reg #(
    parameter int WIDTH = 8,
    parameter int CHANNELS = 4,
    localparam int SEL_W = $clog2(CHANNELS)
) (
    input logic             clk,
    input logic             reset,
    latch_bank_reg_if.slave bus
);
    logic [CHANNELS-1:0][WIDTH-1:0] shadow_q, shadow_d;
    logic [CHANNELS-1:0][WIDTH-1:0] q_q, q_d;
    logic [CHANNELS-1:0]            pending_q, pending_d;
    logic                           sel_err_q, sel_err_d;
    logic                           sel_ok;
    logic [WIDTH-1:0]               cur, nxt;

    always_comb begin
        shadow_d  = shadow_q;
        q_d       = q_q;
        pending_d = pending_q;
        cur       = '0;
        sel_ok    = int'(bus.ch_sel) < CHANNELS;
        sel_err_d = bus.wr_en && !sel_ok;
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.ch_sel == SEL_W'(c)) cur = shadow_q[c];
        end
        // truncating {cur, ser_in} keeps the low WIDTH bits, which also covers WIDTH=1
        nxt = bus.op == 2'b01 ? bus.data :
              bus.op == 2'b10 ? WIDTH'({cur, bus.ser_in}) : '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.commit && pending_q[c]) begin
                q_d[c]       = shadow_q[c];
                pending_d[c] = 1'b0;
            end
            if (bus.wr_en && sel_ok && bus.op != 2'b00 && bus.ch_sel == SEL_W'(c)) begin
                shadow_d[c]  = nxt;
                pending_d[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q  <= '0;
            q_q       <= '0;
            pending_q <= '0;
            sel_err_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            q_q       <= q_d;
            pending_q <= pending_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign bus.q       = q_q;
    assign bus.qn      = ~q_q;
    assign bus.pending = pending_q;
    assign bus.sel_err = sel_err_q;
endmodule

// File: tb/tb_latch_bank_reg.sv
// tb_latch_bank_reg: scenario tasks against three bank configurations (8x4, 1x2, 8x3).
module tb_latch_bank_reg;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int pass_cnt = 0;
    int total_cnt = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_q;

    always #5 clk = ~clk;

    latch_bank_reg_if #(.WIDTH(8), .CHANNELS(4)) b0 ();
    latch_bank_reg_if #(.WIDTH(1), .CHANNELS(2)) b1 ();
    latch_bank_reg_if #(.WIDTH(8), .CHANNELS(3)) b2 ();

    latch_bank_reg #(.WIDTH(8), .CHANNELS(4)) d0 (.clk(clk), .reset(reset), .bus(b0.slave));
    latch_bank_reg #(.WIDTH(1), .CHANNELS(2)) d1 (.clk(clk), .reset(reset), .bus(b1.slave));
    latch_bank_reg #(.WIDTH(8), .CHANNELS(3)) d2 (.clk(clk), .reset(reset), .bus(b2.slave));

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_all();
        b0.wr_en = 0; b0.commit = 0; b0.ch_sel = 0; b0.op = 0; b0.data = 0; b0.ser_in = 0;
        b1.wr_en = 0; b1.commit = 0; b1.ch_sel = 0; b1.op = 0; b1.data = 0; b1.ser_in = 0;
        b2.wr_en = 0; b2.commit = 0; b2.ch_sel = 0; b2.op = 0; b2.data = 0; b2.ser_in = 0;
    endtask

    task automatic wr0(input logic [1:0] ch, input logic [1:0] op, input logic [7:0] d,
                       input logic s, input logic cm);
        b0.wr_en = 1; b0.ch_sel = ch; b0.op = op; b0.data = d; b0.ser_in = s; b0.commit = cm;
        step();
        b0.wr_en = 0; b0.commit = 0;
    endtask

    task automatic wr1(input logic [1:0] op, input logic s, input logic cm);
        b1.wr_en = 1; b1.ch_sel = 1'b0; b1.op = op; b1.data = 1'b0; b1.ser_in = s; b1.commit = cm;
        step();
        b1.wr_en = 0; b1.commit = 0;
    endtask

    task automatic wr2(input logic [1:0] ch, input logic [1:0] op, input logic [7:0] d);
        b2.wr_en = 1; b2.ch_sel = ch; b2.op = op; b2.data = d;
        step();
        b2.wr_en = 0;
    endtask

    task automatic commit0(input logic [31:0] expect_q);
        sb_q.push_back(expect_q);
        b0.commit = 1;
        step();
        b0.commit = 0;
        exp_q = sb_q.pop_front();
        total_cnt++;
        if (b0.q !== exp_q) $display("FAIL commit0_q got=%h exp=%h", b0.q, exp_q);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        idle_all();
        reset = 0;
        repeat (3) step();
        total_cnt += 4;
        if (b0.q !== 32'h0) $display("FAIL rst_held_q got=%h exp=0", b0.q); else pass_cnt++;
        if (b0.qn !== 32'hFFFF_FFFF) $display("FAIL rst_held_qn got=%h exp=ffffffff", b0.qn); else pass_cnt++;
        if (b0.pending !== 4'b0) $display("FAIL rst_held_pending got=%b exp=0000", b0.pending); else pass_cnt++;
        if (b0.sel_err !== 1'b0) $display("FAIL rst_held_sel_err got=%b exp=0", b0.sel_err); else pass_cnt++;
        reset = 1;
        step();
        total_cnt += 3;
        if (b0.q !== 32'h0) $display("FAIL rst_rel_q got=%h exp=0", b0.q); else pass_cnt++;
        if (b0.qn !== 32'hFFFF_FFFF) $display("FAIL rst_rel_qn got=%h exp=ffffffff", b0.qn); else pass_cnt++;
        if (b2.qn !== 24'hFF_FFFF) $display("FAIL rst_rel_qn2 got=%h exp=ffffff", b2.qn); else pass_cnt++;
        wr0(2'd1, 2'b01, 8'h77, 1'b0, 1'b0);
        commit0(32'h0000_7700);
        wr0(2'd2, 2'b01, 8'h12, 1'b0, 1'b0);
        @(posedge clk);
        #2 reset = 0;
        #1;
        total_cnt += 3;
        if (b0.q !== 32'h0) $display("FAIL rst_async_q got=%h exp=0", b0.q); else pass_cnt++;
        if (b0.qn !== 32'hFFFF_FFFF) $display("FAIL rst_async_qn got=%h exp=ffffffff", b0.qn); else pass_cnt++;
        if (b0.pending !== 4'b0) $display("FAIL rst_async_pending got=%b exp=0000", b0.pending); else pass_cnt++;
        @(negedge clk);
        reset = 1;
        step();
    endtask

    task automatic test_atomic();
        wr0(2'd0, 2'b01, 8'hA5, 1'b0, 1'b0);
        wr0(2'd2, 2'b01, 8'h3C, 1'b0, 1'b0);
        total_cnt += 2;
        if (b0.pending !== 4'b0101) $display("FAIL atomic_pending got=%b exp=0101", b0.pending); else pass_cnt++;
        if (b0.q !== 32'h0) $display("FAIL atomic_q_hold got=%h exp=0", b0.q); else pass_cnt++;
        commit0(32'h003C_00A5);
        total_cnt += 2;
        if (b0.qn[7:0] !== 8'h5A) $display("FAIL atomic_qn0 got=%h exp=5a", b0.qn[7:0]); else pass_cnt++;
        if (b0.pending !== 4'b0) $display("FAIL atomic_pending_clr got=%b exp=0000", b0.pending); else pass_cnt++;
        commit0(32'h003C_00A5);
    endtask

    task automatic test_shift();
        wr0(2'd1, 2'b01, 8'h81, 1'b0, 1'b0);
        wr0(2'd1, 2'b10, 8'h00, 1'b1, 1'b0);
        wr0(2'd1, 2'b10, 8'h00, 1'b0, 1'b0);
        wr0(2'd1, 2'b10, 8'h00, 1'b1, 1'b0);
        total_cnt++;
        if (b0.pending !== 4'b0010) $display("FAIL shift_pending got=%b exp=0010", b0.pending); else pass_cnt++;
        commit0(32'h003C_0DA5);
        wr1(2'b10, 1'b1, 1'b0);
        b1.commit = 1; step(); b1.commit = 0;
        total_cnt++;
        if (b1.q !== 2'b01) $display("FAIL shift_w1_one got=%b exp=01", b1.q); else pass_cnt++;
        wr1(2'b10, 1'b0, 1'b0);
        b1.commit = 1; step(); b1.commit = 0;
        total_cnt += 2;
        if (b1.q !== 2'b00) $display("FAIL shift_w1_zero got=%b exp=00", b1.q); else pass_cnt++;
        if (b1.qn !== 2'b11) $display("FAIL shift_w1_qn got=%b exp=11", b1.qn); else pass_cnt++;
    endtask

    task automatic test_collision();
        wr0(2'd3, 2'b01, 8'h11, 1'b0, 1'b0);
        sb_q.push_back(32'h113C_0DA5);
        wr0(2'd3, 2'b01, 8'h22, 1'b0, 1'b1);
        exp_q = sb_q.pop_front();
        total_cnt += 2;
        if (b0.q !== exp_q) $display("FAIL collide_q got=%h exp=%h", b0.q, exp_q); else pass_cnt++;
        if (b0.pending !== 4'b1000) $display("FAIL collide_pending got=%b exp=1000", b0.pending); else pass_cnt++;
        commit0(32'h223C_0DA5);
        wr0(2'd3, 2'b01, 8'h33, 1'b0, 1'b0);
        sb_q.push_back(32'h333C_0DA5);
        wr0(2'd3, 2'b00, 8'h44, 1'b0, 1'b1);
        exp_q = sb_q.pop_front();
        total_cnt += 2;
        if (b0.q !== exp_q) $display("FAIL collide_hold_q got=%h exp=%h", b0.q, exp_q); else pass_cnt++;
        if (b0.pending !== 4'b0000) $display("FAIL collide_hold_pending got=%b exp=0000", b0.pending); else pass_cnt++;
    endtask

    task automatic test_sel_err();
        wr2(2'd1, 2'b01, 8'h5A);
        b2.commit = 1; step(); b2.commit = 0;
        total_cnt += 2;
        if (b2.q !== 24'h00_5A00) $display("FAIL selerr_setup_q got=%h exp=005a00", b2.q); else pass_cnt++;
        if (b2.sel_err !== 1'b0) $display("FAIL selerr_idle got=%b exp=0", b2.sel_err); else pass_cnt++;
        wr2(2'd3, 2'b01, 8'hFF);
        total_cnt += 2;
        if (b2.sel_err !== 1'b1) $display("FAIL selerr_pulse got=%b exp=1", b2.sel_err); else pass_cnt++;
        if (b2.pending !== 3'b000) $display("FAIL selerr_pending got=%b exp=000", b2.pending); else pass_cnt++;
        step();
        total_cnt++;
        if (b2.sel_err !== 1'b0) $display("FAIL selerr_one_cycle got=%b exp=0", b2.sel_err); else pass_cnt++;
        wr2(2'd2, 2'b00, 8'h00);
        total_cnt++;
        if (b2.sel_err !== 1'b0) $display("FAIL selerr_valid got=%b exp=0", b2.sel_err); else pass_cnt++;
        b2.commit = 1; step(); b2.commit = 0;
        total_cnt++;
        if (b2.q !== 24'h00_5A00) $display("FAIL selerr_noop_commit got=%h exp=005a00", b2.q); else pass_cnt++;
        wr2(2'd1, 2'b11, 8'h00);
        b2.commit = 1; step(); b2.commit = 0;
        total_cnt += 2;
        if (b2.q !== 24'h0) $display("FAIL clear_q got=%h exp=0", b2.q); else pass_cnt++;
        if (b2.qn !== 24'hFF_FFFF) $display("FAIL clear_qn got=%h exp=ffffff", b2.qn); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 4; c++) wr0(2'(c), 2'b01, 8'(8'hC0 + c), 1'b0, 1'b0);
        total_cnt++;
        if (b0.pending !== 4'b1111) $display("FAIL rmid_pending_set got=%b exp=1111", b0.pending); else pass_cnt++;
        reset = 0;
        step();
        reset = 1;
        step();
        commit0(32'h0);
        total_cnt++;
        if (b0.pending !== 4'b0) $display("FAIL rmid_pending got=%b exp=0000", b0.pending); else pass_cnt++;
    endtask

    initial begin
        idle_all();
        @(negedge clk);
        test_reset();
        test_atomic();
        test_shift();
        test_collision();
        test_sel_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
